// File: rtl/bus_rr_router_pkg.sv
// Shared types and helpers for the round-robin packet router.
// Packets carry a destination id in their upper byte.
package bus_router_pkg;

  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BCAST_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    PUSH
  } state_t;

  // Extract the destination id from a packet of width pkt_w, zero-extended to 64 bits.
  function automatic logic [ID_W-1:0] pkt_id(input logic [63:0] pkt, input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_rr_router_if.sv
// Per-terminal FIFO handshake between the terminals and the router.
// The slave modport is the router side; the master modport is the terminal side.
interface bus_rr_router_if #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
) ();

  logic [DRVRS-1:0]         pndng;
  logic [DRVRS*PCKG_SZ-1:0] d_pop;
  logic [DRVRS-1:0]         pop;
  logic [DRVRS-1:0]         push;
  logic [DRVRS*PCKG_SZ-1:0] d_push;

  modport slave (
    input  pndng,
    input  d_pop,
    output pop,
    output push,
    output d_push
  );

  modport master (
    output pndng,
    output d_pop,
    input  pop,
    input  push,
    input  d_push
  );

endinterface

// File: rtl/bus_rr_router_rr_arbiter.sv
// Combinational rotating-priority encoder: first set request at or above
// i_base, wrapping around to index 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_base,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any_req
);

  // Scanning from the far end down lets the lowest offset from i_base win.
  always_comb begin
    int k;
    k         = 0;
    o_grant   = '0;
    o_any_req = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(i_base) + i;
      if (k >= N) k = k - N;
      if (i_req[k]) begin
        o_grant   = PTR_W'(k);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_router.sv
// Bus-side responder: pops one packet at a time from pending terminals in
// round-robin order and delivers it to one terminal or broadcasts it.
//
// state | meaning
// IDLE  | waiting for any pndng; latches the round-robin grant
// POP   | pops the granted terminal's head and captures it
// PUSH  | decodes the id and pushes (or drops) the captured packet
module bus_rr_router
  import bus_router_pkg::*;
#(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter logic [ID_W-1:0] BROADCAST = BCAST_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  bus_rr_router_if.slave     bus,
  output logic               o_busy,
  output logic [15:0]        o_drop_cnt
);

  localparam int PTR_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  state_t                   r_state;
  logic [PTR_W-1:0]         r_grant;
  logic [PTR_W-1:0]         r_rr_ptr;
  logic [PCKG_SZ-1:0]       r_pkt;
  logic [DRVRS-1:0]         r_pop;
  logic [DRVRS-1:0]         r_push;
  logic [DRVRS*PCKG_SZ-1:0] r_d_push;
  logic                     r_busy;
  logic [15:0]              r_drop_cnt;

  logic [PTR_W-1:0]         w_arb_grant;
  logic                     w_any_req;
  logic [ID_W-1:0]          w_id;
  logic [DRVRS-1:0]         w_push_mask;
  logic                     w_drop;
  logic [PCKG_SZ-1:0]       w_pkt_in;
  logic [PTR_W-1:0]         w_ptr_next;

  rr_arbiter #(
    .N     (DRVRS),
    .PTR_W (PTR_W)
  ) u_arb (
    .i_req     (bus.pndng),
    .i_base    (r_rr_ptr),
    .o_grant   (w_arb_grant),
    .o_any_req (w_any_req)
  );

  assign w_pkt_in   = bus.d_pop[int'(r_grant)*PCKG_SZ +: PCKG_SZ];
  assign w_id       = pkt_id(64'(r_pkt), PCKG_SZ);
  assign w_ptr_next = (int'(r_grant) == DRVRS - 1) ? '0 : r_grant + 1'b1;

  // Broadcast is checked first; a unicast to the source itself is a drop.
  always_comb begin
    w_push_mask = '0;
    w_drop      = 1'b0;
    if (w_id == BROADCAST) begin
      for (int j = 0; j < DRVRS; j++) begin
        w_push_mask[j] = (j != int'(r_grant));
      end
    end else if ((int'(w_id) < DRVRS) && (int'(w_id) != int'(r_grant))) begin
      w_push_mask[w_id[PTR_W-1:0]] = 1'b1;
    end else begin
      w_drop = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_rr_ptr   <= '0;
      r_pkt      <= '0;
      r_pop      <= '0;
      r_push     <= '0;
      r_d_push   <= '0;
      r_busy     <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_pop  <= '0;
      r_push <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_grant <= w_arb_grant;
            r_state <= POP;
            r_busy  <= 1'b1;
          end
        end
        POP: begin
          if (bus.pndng[r_grant]) begin
            r_pop[r_grant] <= 1'b1;
            r_pkt          <= w_pkt_in;
            r_state        <= PUSH;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        PUSH: begin
          r_push   <= w_push_mask;
          r_d_push <= {DRVRS{r_pkt}};
          if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
          r_rr_ptr <= w_ptr_next;
          r_state  <= IDLE;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pop    = r_pop;
  assign bus.push   = r_push;
  assign bus.d_push = r_d_push;
  assign o_busy     = r_busy;
  assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_bus_rr_router.sv
// Self-checking bench for bus_rr_router: terminal FIFOs are modelled as
// queues, and a transaction-level model predicts grants, deliveries and drops.
module tb_bus_rr_router;

  logic        clk;
  logic        rst;
  logic        busy;
  logic [15:0] drop_cnt;

  bus_rr_router_if #(.DRVRS(4), .PCKG_SZ(16)) bus ();

  bus_rr_router #(.DRVRS(4), .PCKG_SZ(16), .BROADCAST(8'hFF)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .bus        (bus),
    .o_busy     (busy),
    .o_drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  logic [15:0] q [4][$];
  int          model_ptr = 0;
  int          exp_drops = 0;
  logic [63:0] exp_dpush = '0;
  bit          pend = 0;
  int          pend_src = 0;
  logic [15:0] pend_pkt = '0;
  bit          manual = 0;
  bit          gap_check = 0;
  int          cyc = 0;
  int          pop_cyc = -1;
  int          last_pop_cyc = -1;
  int          last_push_cyc = -1;
  logic [3:0]  last_push = '0;
  int          pop_log [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Delivery rule: broadcast goes to everyone but the source; a unicast to a
  // real terminal other than the source goes there; anything else is dropped.
  function automatic logic [3:0] exp_mask(input logic [15:0] pkt, input int src);
    int id;
    id = int'(pkt[15:8]);
    if (id == 255) return 4'hF & ~(4'd1 << src);
    if (id < 4 && id != src) return 4'd1 << id;
    return 4'h0;
  endfunction

  function automatic int rr_pick();
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (model_ptr + k) % 4;
      if (q[i].size() != 0) return i;
    end
    return -1;
  endfunction

  function automatic bit any_pending();
    for (int s = 0; s < 4; s++) if (q[s].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int s = 0; s < 4; s++) begin
      bus.pndng[s]         = (q[s].size() != 0);
      bus.d_pop[s*16 +: 16] = (q[s].size() != 0) ? q[s][0] : 16'h0;
    end
  endtask

  task automatic tick();
    logic [3:0] em;
    int src;
    int act;
    @(posedge clk);
    #1;
    cyc++;
    em = 4'h0;
    if (pend) begin
      em = exp_mask(pend_pkt, pend_src);
      exp_dpush = {4{pend_pkt}};
      if (em == 4'h0) exp_drops++;
      model_ptr = (pend_src + 1) % 4;
      pend = 0;
    end
    if (bus.push != 4'h0) begin
      last_push = bus.push;
      last_push_cyc = cyc;
    end
    chk("push", 64'(bus.push), 64'(em));
    chk("d_push", bus.d_push, exp_dpush);
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    if (bus.pop != 4'h0) begin
      src = rr_pick();
      chk("pop_grant", 64'(bus.pop), (src >= 0) ? 64'(4'd1 << src) : 64'h0);
      act = -1;
      for (int b = 0; b < 4; b++) if (bus.pop[b]) act = b;
      pop_log.push_back(act);
      if (src >= 0) begin
        pend_pkt = q[src].pop_front();
        pend_src = src;
        pend = 1;
      end
      if (gap_check && last_pop_cyc >= 0) chk("pop_gap", 64'(cyc - last_pop_cyc), 64'd3);
      last_pop_cyc = cyc;
      pop_cyc = cyc;
    end
    if (!manual) drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((any_pending() || pend || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 4; s++) q[s].delete();
    model_ptr = 0;
    exp_drops = 0;
    exp_dpush = '0;
    pend = 0;
    manual = 0;
    last_push = '0;
    drive();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int start;
    int n;
    int nb;
    int s;
    int sel;
    logic [7:0] id;

    rst = 1'b1;
    bus.pndng = '0;
    bus.d_pop = '0;

    // Reset state
    do_reset();
    chk("rst_pop", 64'(bus.pop), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);

    // Unicast 0 -> 2 with exact latency
    q[0].push_back(16'h02A5);
    drive();
    start = cyc;
    tick();
    chk("uni_busy", 64'(busy), 64'd1);
    chk("uni_no_early_pop", 64'(bus.pop), 64'h0);
    drain(20);
    chk("uni_pop_lat", 64'(pop_cyc - start), 64'd2);
    chk("uni_push_lat", 64'(last_push_cyc - start), 64'd3);
    chk("uni_mask", 64'(last_push), 64'h4);
    chk("uni_busy_end", 64'(busy), 64'h0);

    // Broadcast from terminal 1
    q[1].push_back(16'hFF3C);
    drive();
    drain(20);
    chk("bcast_mask", 64'(last_push), 64'hD);
    chk("bcast_data", bus.d_push, 64'hFF3CFF3CFF3CFF3C);

    // Round-robin with all terminals continuously pending
    do_reset();
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 3; k++) begin
        id = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'((t + 1 + $urandom_range(0, 2)) % 4);
        q[t].push_back({id, 8'($urandom)});
      end
    end
    pop_log.delete();
    gap_check = 1;
    last_pop_cyc = -1;
    drive();
    drain(100);
    gap_check = 0;
    chk("rr_count", 64'(pop_log.size()), 64'd12);
    for (int k = 0; k < pop_log.size(); k++) chk("rr_order", 64'(pop_log[k]), 64'(k % 4));
    chk("rr_drops", 64'(drop_cnt), 64'h0);

    // Drops: self-addressed and out-of-range ids
    do_reset();
    q[3].push_back(16'h0311);
    q[3].push_back(16'h0922);
    drive();
    drain(40);
    chk("drop_cnt2", 64'(drop_cnt), 64'd2);
    chk("drop_no_push", 64'(last_push), 64'h0);
    q[0].push_back(16'h01AB);
    drive();
    drain(20);
    chk("drop_next_mask", 64'(last_push), 64'h2);
    chk("drop_next_data", bus.d_push, 64'h01AB01AB01AB01AB);

    // Reset in the cycle after pop[1]
    do_reset();
    q[1].push_back(16'h0255);
    drive();
    n = 0;
    while (bus.pop == 4'h0 && n < 10) begin
      tick();
      n++;
    end
    chk("rstmid_pop", 64'(bus.pop), 64'h2);
    rst = 1'b1;
    pend = 0;
    model_ptr = 0;
    exp_drops = 0;
    exp_dpush = '0;
    last_push = '0;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", 64'(busy), 64'h0);
    tick();
    chk("rstmid_no_push", 64'(last_push), 64'h0);
    pop_log.delete();
    q[1].push_back(16'h0344);
    drive();
    drain(20);
    chk("rstmid_regrant", 64'(pop_log.size() > 0 ? pop_log[0] : -1), 64'd1);
    chk("rstmid_deliver", 64'(last_push), 64'h8);

    // pndng[2] glitches away between grant and pop
    manual = 1;
    bus.pndng = 4'b0100;
    bus.d_pop = 64'h0000_0155_0000_0000;
    tick();
    chk("glitch_granted", 64'(busy), 64'd1);
    bus.pndng = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("glitch_no_pop", 64'(bus.pop), 64'h0);
    end
    chk("glitch_idle", 64'(busy), 64'h0);
    chk("glitch_drops", 64'(drop_cnt), 64'(exp_drops));
    manual = 0;
    pop_log.delete();
    q[1].push_back(16'h0211);
    q[3].push_back(16'h0022);
    drive();
    drain(40);
    chk("glitch_ptr_kept", 64'(pop_log.size() > 0 ? pop_log[0] : -1), 64'd3);

    // Randomized bursts checked against the model
    for (int b = 0; b < 25; b++) begin
      nb = $urandom_range(1, 8);
      for (int k = 0; k < nb; k++) begin
        s = $urandom_range(0, 3);
        sel = $urandom_range(0, 5);
        if (sel < 4) id = 8'(sel);
        else if (sel == 4) id = 8'hFF;
        else id = 8'($urandom_range(4, 254));
        q[s].push_back({id, 8'($urandom)});
      end
      drive();
      drain(200);
    end
    chk("rand_drops", 64'(drop_cnt), 64'(exp_drops));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/bus_rr_router.md
Name: bus_rr_router

Overview:
- Bus-side responder for the per-terminal FIFO handshake that the Driver_Monitor agents drive and observe.
- Pops one packet at a time from source terminals asserting pndng, using round-robin grant.
- Decodes the destination id in the packet's upper byte and pushes the packet to one destination terminal, or broadcasts it to all other terminals.
- Serves as the reference RTL bus under the driver/monitor/checker environment.

Parameters:
- drvrs, 4, number of terminals (2..16)
- pckg_sz, 16, packet width in bits; packet = {id[7:0], dato[pckg_sz-9:0]}
- broadcast, 8'hFF, id value meaning "deliver to all terminals except the source"

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pndng  in  drvrs  terminal i has a packet at its FIFO head
- d_pop  in  drvrs*pckg_sz  head data of terminal i (lane i = bits [i*pckg_sz +: pckg_sz]); first-word-fall-through, valid while pndng[i]
- pop  out  drvrs  one-cycle pulse: consume the head of terminal i
- push  out  drvrs  one-cycle pulse: write d_push lane i into terminal i
- d_push  out  drvrs*pckg_sz  delivered packet, replicated on every lane
- busy  out  1  FSM not in IDLE
- drop_cnt  out  16  saturating count of undeliverable packets

Behaviour:
- Reset (synchronous, clk edge with reset=1) forces:
  - state=IDLE; rr_ptr=0
  - pop=0, push=0, d_push=0, busy=0, drop_cnt=0
  - any captured packet is discarded
- All outputs are registered.
- FSM states: IDLE, POP, PUSH.
- IDLE:
  - If pndng==0, stay in IDLE.
  - Otherwise, select grant g = first set bit of pndng scanning upward from rr_ptr, with wrap-around. Register g and go to POP.
- POP:
  - If pndng[g]==1: pop[g]=1 for exactly this cycle; capture pkt=d_pop lane g; go to PUSH.
  - If pndng[g]==0 (protocol violation): no pop, no count; return to IDLE; rr_ptr unchanged.
- PUSH: decode id = pkt[pckg_sz-1 -: 8].
  - id<drvrs and id!=g: push[id]=1.
  - id==broadcast: push[j]=1 for every j!=g.
  - Any other id (out of range, or id==g): no push; drop_cnt += 1, saturating at 16'hFFFF.
  - In all cases: d_push lanes = pkt; rr_ptr = (g+1) mod drvrs; go to IDLE.
- d_push holds its last value until the next PUSH.
- Latency: pndng seen in IDLE at cycle t → pop at t+1 → push at t+2 → IDLE at t+3. Peak rate is one packet per 3 cycles.
- Fairness: with all pndng continuously high, grants follow 0,1,2,...,drvrs-1,0,...
- Only the source granted in IDLE is serviced. New pndng bits are ignored until the next IDLE.
- pop and push are never asserted in the same cycle. At most one pop bit is ever set.
- Reset asserted during POP or PUSH:
  - Outputs are 0 on the next cycle.
  - A packet already popped but not yet pushed is lost; no push is issued.
- drvrs > 255 is not supported; ids >= drvrs other than broadcast are drops.

Decomposition:
- Package bus_router_pkg:
  - state enum {IDLE, POP, PUSH}
  - ID_W=8 and the default broadcast constant
  - function pkt_id(pkt) returning the upper ID_W bits
- Sub-module rr_arbiter:
  - Combinational rotating-priority encoder.
  - Inputs: req[drvrs], base ptr.
  - Outputs: grant index, any_req.
- Top holds the FSM, packet register, drop counter and rr_ptr.

Test Plan:
- Unicast: reset, then pndng[0]=1 with d_pop lane0=16'h02A5 → pop[0] one cycle later; push[2] with d_push=16'h02A5 two cycles after pop request; drop_cnt=0.
- Broadcast: terminal 1 sends 16'hFF3C → push=4'b1101 in a single cycle; all lanes carry 16'hFF3C.
- Round-robin: pndng=4'b1111 held for 12 packets, all to valid ids → pop order 0,1,2,3,0,1,2,3,0,1,2,3; one pop every 3 cycles.
- Drops: terminal 3 sends id=8'h03 (self), then id=8'h09 → no push for either; drop_cnt=2; next valid packet delivered normally.
- Reset mid-operation: assert reset in the cycle after pop[1] → push stays 0, busy=0, rr_ptr=0; next pndng=4'b0010 is granted to terminal 1.
- Glitch: pndng[2] drops before POP → no pop or push; FSM back in IDLE; drop_cnt unchanged.
